// File: rtl/johnson_pkg.sv
// Shared encodings and width-generic decode/encode helpers for the Johnson/ring counter.
// Helpers take vectors zero-extended to JC_MAXW bits and the live width as an argument.
package johnson_pkg;
  localparam logic MODE_JOHNSON = 1'b0;
  localparam logic MODE_RING    = 1'b1;
  localparam int   JC_MAXW      = 64;

  typedef logic [JC_MAXW-1:0] jc_vec_t;

  // A Johnson pattern is any word with at most one transition between neighbouring bits.
  function automatic logic jc_legal(input jc_vec_t q, input int w);
    int t;
    t = 0;
    for (int i = 0; i < JC_MAXW-1; i++)
      if (i < w-1 && q[i] != q[i+1]) t++;
    return t <= 1;
  endfunction

  function automatic int jc_phase(input jc_vec_t q, input int w);
    int ones;
    ones = 0;
    for (int i = 0; i < JC_MAXW; i++)
      if (i < w && q[i]) ones++;
    if (!q[w-1]) return ones;
    return w + (w - ones);
  endfunction

  function automatic jc_vec_t jc_encode(input int k, input int w);
    jc_vec_t v;
    v = '0;
    for (int i = 0; i < JC_MAXW; i++)
      if (i < w) v[i] = (k <= w) ? (i < k) : (i >= k - w);
    return v;
  endfunction

  function automatic logic ring_legal(input jc_vec_t q, input int w);
    int ones;
    ones = 0;
    for (int i = 0; i < JC_MAXW; i++)
      if (i < w && q[i]) ones++;
    return ones == 1;
  endfunction

  function automatic int ring_phase(input jc_vec_t q, input int w);
    int idx;
    idx = 0;
    for (int i = 0; i < JC_MAXW; i++)
      if (i < w && q[i]) idx = i;
    return idx;
  endfunction

  function automatic jc_vec_t ring_encode(input int k, input int w);
    jc_vec_t v;
    v = '0;
    for (int i = 0; i < JC_MAXW; i++)
      if (i < w) v[i] = (i == k);
    return v;
  endfunction
endpackage

// File: rtl/jcg_decode.sv
// Combinational legality check and binary phase decode of a Johnson or ring state.
module jcg_decode
  import johnson_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int PW    = $clog2(2*WIDTH)
) (
  input  logic [WIDTH-1:0] q,
  input  logic             mode,
  output logic             legal,
  output logic [PW-1:0]    phase
);
  jc_vec_t q_ext;
  int      ph;

  always_comb begin
    q_ext = jc_vec_t'(q);
    if (mode == MODE_RING) begin
      legal = ring_legal(q_ext, WIDTH);
      ph    = ring_phase(q_ext, WIDTH);
    end else begin
      legal = jc_legal(q_ext, WIDTH);
      ph    = jc_phase(q_ext, WIDTH);
    end
    phase = legal ? PW'(ph) : '0;
  end
endmodule

// File: rtl/johnson_counter_gen.sv
// Parametrised Johnson / one-hot ring counter with direction, enable, phase load,
// wrap pulse and illegal-state detection with optional self-correction.
module johnson_counter_gen
  import johnson_pkg::*;
#(
  parameter  int WIDTH        = 4,
  parameter  bit SELF_CORRECT = 1'b1,
  localparam int PW           = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             ring_mode,
  input  logic             load,
  input  logic [PW-1:0]    load_phase,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [PW-1:0]    phase,
  output logic             wrap,
  output logic             illegal,
  output logic             err_sticky
);
  logic             mode_q, legal;
  logic [PW:0]      n_states;   // one extra bit: 2*WIDTH may equal 2**PW
  logic [PW-1:0]    last_phase;
  logic             load_ok, step_wrap, err_set;
  logic [WIDTH-1:0] step_q, load_q;
  jc_vec_t          enc;

  jcg_decode #(.WIDTH(WIDTH)) u_dec (
    .q     (q),
    .mode  (mode_q),
    .legal (legal),
    .phase (phase)
  );

  assign illegal = ~legal;

  always_comb begin
    n_states   = (mode_q == MODE_RING) ? (PW+1)'(WIDTH) : (PW+1)'(2*WIDTH);
    last_phase = PW'(n_states - 1'b1);
    load_ok    = {1'b0, load_phase} < n_states;
    enc        = (mode_q == MODE_RING) ? ring_encode(int'(load_phase), WIDTH)
                                       : jc_encode(int'(load_phase), WIDTH);
    load_q     = enc[WIDTH-1:0];
    // Ring recirculates the exiting bit, Johnson recirculates its complement.
    if (!dir) step_q = {q[WIDTH-2:0], (mode_q == MODE_RING) ? q[WIDTH-1] : ~q[WIDTH-1]};
    else      step_q = {(mode_q == MODE_RING) ? q[0] : ~q[0], q[WIDTH-1:1]};
    step_wrap  = legal && (dir ? (phase == '0) : (phase == last_phase));
    err_set    = load ? ~load_ok : illegal;
  end

  wire unused_enc = &{1'b0, enc};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q          <= '0;
      mode_q     <= MODE_JOHNSON;
      wrap       <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (ring_mode != mode_q) begin
        mode_q <= ring_mode;
        q      <= {{(WIDTH-1){1'b0}}, ring_mode};
      end else begin
        if (load) begin
          if (load_ok) q <= load_q;
        end else if (illegal && SELF_CORRECT) begin
          q <= {{(WIDTH-1){1'b0}}, mode_q};
        end else if (en) begin
          q    <= step_q;
          wrap <= step_wrap;
        end
        err_sticky <= err_set | (err_sticky & ~clr_err);
      end
    end
  end
endmodule

// File: tb/tb_johnson_counter_gen.sv
// Bench for johnson_counter_gen: directed vector table, corner sequences, and a
// randomized run against a phase-index reference model.
module tb_johnson_counter_gen;
  localparam int W  = 4;
  localparam int PW = $clog2(2*W);

  logic clk = 1'b0, rst = 1'b0;
  logic en = 0, dir = 0, ring_mode = 0, load = 0, clr_err = 0;
  logic [PW-1:0] load_phase = '0;
  logic [W-1:0]  q, q2;
  logic [PW-1:0] phase, phase2;
  logic wrap, wrap2, illegal, illegal2, err, err2;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  johnson_counter_gen #(.WIDTH(W), .SELF_CORRECT(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .ring_mode(ring_mode), .load(load),
    .load_phase(load_phase), .clr_err(clr_err), .q(q), .phase(phase), .wrap(wrap),
    .illegal(illegal), .err_sticky(err));

  johnson_counter_gen #(.WIDTH(W), .SELF_CORRECT(1'b0)) dut_nc (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .ring_mode(ring_mode), .load(load),
    .load_phase(load_phase), .clr_err(clr_err), .q(q2), .phase(phase2), .wrap(wrap2),
    .illegal(illegal2), .err_sticky(err2));

  typedef struct packed {
    logic en, dir, rm, ld;
    logic [PW-1:0] lp;
    logic clr;
    logic [W-1:0] q;
    logic [PW-1:0] ph;
    logic w, e;
  } vec_t;

  vec_t tbl[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic e_, d_, rm_, ld_, input int lp_, input logic clr_,
                              input logic [W-1:0] q_, input int ph_, input logic w_, er_);
    vec_t v;
    v = '{en:e_, dir:d_, rm:rm_, ld:ld_, lp:PW'(lp_), clr:clr_, q:q_, ph:PW'(ph_), w:w_, e:er_};
    return v;
  endfunction

  // Reference: state is tracked as (mode, phase index); the bit pattern is derived arithmetically.
  function automatic logic [W-1:0] model_q(input logic m, input int ph);
    if (m) return W'(1) << ph;
    if (ph <= W) return W'((1 << ph) - 1);
    return W'(((1 << W) - 1) & ~((1 << (ph - W)) - 1));
  endfunction

  logic m_mode, m_wrap, m_err;
  int   m_ph;

  task automatic model_step();
    int states;
    states = m_mode ? W : 2*W;
    m_wrap = 1'b0;
    if (ring_mode != m_mode) begin
      m_mode = ring_mode;
      m_ph   = 0;
    end else begin
      logic set;
      set = load && (int'(load_phase) >= states);
      if (load) begin
        if (int'(load_phase) < states) m_ph = int'(load_phase);
      end else if (en) begin
        if (!dir) begin m_wrap = (m_ph == states-1); m_ph = (m_ph + 1) % states; end
        else      begin m_wrap = (m_ph == 0);        m_ph = (m_ph + states - 1) % states; end
      end
      m_err = set | (m_err & ~clr_err);
    end
  endtask

  task automatic set_in(input logic e_, d_, rm_, ld_, input int lp_, input logic clr_);
    en = e_; dir = d_; ring_mode = rm_; load = ld_; load_phase = PW'(lp_); clr_err = clr_;
  endtask

  initial begin
    tbl[0]  = mk(1,0,0,0,0,0, 4'b0001,1,0,0);
    tbl[1]  = mk(1,0,0,0,0,0, 4'b0011,2,0,0);
    tbl[2]  = mk(1,0,0,0,0,0, 4'b0111,3,0,0);
    tbl[3]  = mk(1,0,0,0,0,0, 4'b1111,4,0,0);
    tbl[4]  = mk(1,0,0,0,0,0, 4'b1110,5,0,0);
    tbl[5]  = mk(1,0,0,0,0,0, 4'b1100,6,0,0);
    tbl[6]  = mk(1,0,0,0,0,0, 4'b1000,7,0,0);
    tbl[7]  = mk(1,0,0,0,0,0, 4'b0000,0,1,0);
    tbl[8]  = mk(1,1,0,0,0,0, 4'b1000,7,1,0);
    tbl[9]  = mk(1,1,0,0,0,0, 4'b1100,6,0,0);
    tbl[10] = mk(1,0,0,1,5,0, 4'b1110,5,0,0);
    tbl[11] = mk(0,0,1,1,6,0, 4'b0001,0,0,0);
    tbl[12] = mk(0,0,1,1,6,0, 4'b0001,0,0,1);
    tbl[13] = mk(1,0,1,0,0,1, 4'b0010,1,0,0);
    tbl[14] = mk(1,0,1,0,0,0, 4'b0100,2,0,0);
    tbl[15] = mk(1,0,1,0,0,0, 4'b1000,3,0,0);
    tbl[16] = mk(1,0,1,0,0,0, 4'b0001,0,1,0);
    tbl[17] = mk(1,0,0,0,0,0, 4'b0000,0,0,0);

    // Asynchronous reset state, before any clock edge.
    #1;
    check("rst_q", 32'(q), 0);
    check("rst_phase", 32'(phase), 0);
    check("rst_wrap", 32'(wrap), 0);
    check("rst_err", 32'(err), 0);
    check("rst_illegal", 32'(illegal), 0);
    @(negedge clk);
    rst = 1'b1;

    foreach (tbl[i]) begin
      set_in(tbl[i].en, tbl[i].dir, tbl[i].rm, tbl[i].ld, int'(tbl[i].lp), tbl[i].clr);
      cyc();
      check($sformatf("tbl%0d_q", i), 32'(q), 32'(tbl[i].q));
      check($sformatf("tbl%0d_phase", i), 32'(phase), 32'(tbl[i].ph));
      check($sformatf("tbl%0d_wrap", i), 32'(wrap), 32'(tbl[i].w));
      check($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].e));
    end

    // Illegal pattern 0101 in Johnson mode, with and without self-correction.
    set_in(1, 0, 0, 0, 0, 0);
    force dut.q = 4'b0101;
    force dut_nc.q = 4'b0101;
    #1;
    check("ill_flag", 32'(illegal), 1);
    check("ill_phase", 32'(phase), 0);
    check("ill_flag_nc", 32'(illegal2), 1);
    release dut.q;
    release dut_nc.q;
    cyc();
    check("corr_q", 32'(q), 0);
    check("corr_err", 32'(err), 1);
    check("corr_wrap", 32'(wrap), 0);
    check("nc_q", 32'(q2), 32'(4'b1011));
    check("nc_err", 32'(err2), 1);
    clr_err = 1'b1;
    cyc();
    check("clr_err", 32'(err), 0);
    check("clr_q", 32'(q), 32'(4'b0001));
    check("nc_err_hold", 32'(err2), 1);

    // Asynchronous reset mid-sequence, at phase 5 with err_sticky set.
    rst = 1'b0; set_in(0, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    set_in(0, 0, 1, 0, 0, 0); cyc();
    set_in(0, 0, 1, 1, 6, 0); cyc();
    set_in(0, 0, 0, 0, 0, 0); cyc();
    check("pre_err", 32'(err), 1);
    set_in(1, 0, 0, 0, 0, 0);
    repeat (5) cyc();
    check("pre_q", 32'(q), 32'(4'b1110));
    #2 rst = 1'b0;
    #1;
    check("async_q", 32'(q), 0);
    check("async_err", 32'(err), 0);
    check("async_wrap", 32'(wrap), 0);
    check("async_phase", 32'(phase), 0);
    @(negedge clk);
    rst = 1'b1;
    cyc();
    check("resume_q", 32'(q), 32'(4'b0001));
    check("resume_phase", 32'(phase), 1);

    // Reset released with ring_mode=1: first edge applies the mode change.
    rst = 1'b0; set_in(1, 0, 1, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    cyc();
    check("rst_ring_q", 32'(q), 32'(4'b0001));
    check("rst_ring_wrap", 32'(wrap), 0);

    // Randomized run against the phase-index model.
    rst = 1'b0; set_in(0, 0, 0, 0, 0, 0);
    m_mode = 0; m_ph = 0; m_wrap = 0; m_err = 0;
    @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      en         = ($urandom_range(3) != 0);
      dir        = 1'($urandom);
      ring_mode  = ($urandom_range(19) == 0) ? ~ring_mode : ring_mode;
      load       = ($urandom_range(9) == 0);
      load_phase = PW'($urandom);
      clr_err    = ($urandom_range(7) == 0);
      model_step();
      cyc();
      check("rnd_q", 32'(q), 32'(model_q(m_mode, m_ph)));
      check("rnd_phase", 32'(phase), 32'(m_ph));
      check("rnd_wrap", 32'(wrap), 32'(m_wrap));
      check("rnd_err", 32'(err), 32'(m_err));
      check("rnd_illegal", 32'(illegal), 0);
      check("rnd_nc_q", 32'(q2), 32'(model_q(m_mode, m_ph)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
